// File: rtl/core_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_sched_pkg
// Description : Shared types and widths for the compute-core job scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package core_sched_pkg;

    localparam int CORE_IN_W  = 16;
    localparam int CORE_OUT_W = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GRANT     = 3'd1,
        LAUNCH    = 3'd2,
        WAIT_BUSY = 3'd3,
        RUN       = 3'd4,
        RESP      = 3'd5
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/core_job_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: the first asserted request
//               at or after the pointer, wrapping, as one-hot and as index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDW   = 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDW-1:0]   i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDW-1:0]   o_idx,
    output logic             o_any
);

    // Scan from the pointer upward; the first hit wins and masks later ones.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!o_any && i_req[(int'(i_ptr) + k) % N_REQ]) begin
                o_any                               = 1'b1;
                o_gnt[(int'(i_ptr) + k) % N_REQ]    = 1'b1;
                o_idx                               = IDW'((int'(i_ptr) + k) % N_REQ);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/core_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : core_job_scheduler
// Description : Shares one start/busy compute core among N_REQ requesters.
//               Round-robin grant, single-cycle start pulse, held operand,
//               result capture with busy/start timeouts, response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module core_job_scheduler
    import core_sched_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int IDW        = 1,
    parameter int START_WAIT = 4,
    parameter int RUN_TO     = 4096
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [CORE_IN_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [IDW-1:0]             rsp_id,
    output logic [CORE_OUT_W-1:0]      rsp_data,
    output logic                       rsp_err,
    output logic                       core_st,
    output logic [CORE_IN_W-1:0]       core_in,
    input  logic                       core_busy,
    input  logic [CORE_OUT_W-1:0]      core_out,
    output logic                       active
);

    localparam int                c_cnt_w      = $clog2(RUN_TO + 1);
    localparam logic [c_cnt_w-1:0] c_start_wait = c_cnt_w'(START_WAIT);
    localparam logic [c_cnt_w-1:0] c_run_to     = c_cnt_w'(RUN_TO);

    sched_state_t            r_state;
    logic [IDW-1:0]          r_ptr;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [CORE_IN_W-1:0]    r_core_in;
    logic                    r_core_st;
    logic                    r_rsp_valid;
    logic [IDW-1:0]          r_rsp_id;
    logic [CORE_OUT_W-1:0]   r_rsp_data;
    logic                    r_rsp_err;
    logic                    r_active;

    logic [N_REQ-1:0]        w_gnt;
    logic [IDW-1:0]          w_idx;
    logic                    w_any;
    logic [IDW-1:0]          w_ptr_next;
    logic [c_cnt_w-1:0]      w_cnt_inc;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Pointer moves one past the winner so the winner goes to the back of the line.
    assign w_ptr_next = (int'(w_idx) == N_REQ - 1) ? '0 : w_idx + 1'b1;
    // Saturating counter step shared by the start-wait and run-timeout phases.
    assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    // Ready is the live arbiter pick, offered only during the grant cycle.
    assign req_ready = (r_state == GRANT) ? w_gnt : '0;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign core_st   = r_core_st;
    assign core_in   = r_core_in;
    assign active    = r_active;

    // Job sequencer: grant, launch, wait for busy, run, hold the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_core_in   <= '0;
            r_core_st   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_active    <= 1'b0;
        end else begin
            r_core_st <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Never start the core while it is still busy with an abandoned job.
                    if (|req_valid && !core_busy) begin
                        r_state  <= GRANT;
                        r_active <= 1'b1;
                    end
                end
                GRANT: begin
                    if (w_any) begin
                        r_core_in <= req_data[CORE_IN_W*w_idx +: CORE_IN_W];
                        r_rsp_id  <= w_idx;
                        r_ptr     <= w_ptr_next;
                        r_core_st <= 1'b1;
                        r_state   <= LAUNCH;
                    end else begin
                        r_state  <= IDLE;
                        r_active <= 1'b0;
                    end
                end
                LAUNCH: begin
                    r_cnt   <= '0;
                    r_state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (core_busy) begin
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end else if (r_cnt >= c_start_wait) begin
                        // Busy never rose: the core finished within the start window.
                        r_rsp_data  <= core_out;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                RUN: begin
                    if (!core_busy) begin
                        r_rsp_data  <= core_out;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else if (r_cnt >= c_run_to) begin
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_active    <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_core_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_job_scheduler
// Description : Self-checking bench for core_job_scheduler with a behavioural
//               core model and a queue-based reference scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_job_scheduler;

    localparam int N_REQ      = 2;
    localparam int IDW        = 1;
    localparam int START_WAIT = 4;
    localparam int RUN_TO     = 4096;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N_REQ-1:0]      req_valid;
    logic [16*N_REQ-1:0]   req_data;
    logic [N_REQ-1:0]      req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [31:0]           rsp_data;
    logic                  rsp_err;
    logic                  core_st;
    logic [15:0]           core_in;
    logic                  core_busy;
    logic [31:0]           core_out;
    logic                  active;

    always #5 clk = ~clk;

    core_job_scheduler #(
        .N_REQ      (N_REQ),
        .IDW        (IDW),
        .START_WAIT (START_WAIT),
        .RUN_TO     (RUN_TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .core_st   (core_st),
        .core_in   (core_in),
        .core_busy (core_busy),
        .core_out  (core_out),
        .active    (active)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Core behaviour: mode 0 normal, mode 1 zero-latency (busy never rises), mode 2 hang.
    function automatic logic [31:0] core_fn(input logic [15:0] op);
        return {op, op ^ 16'hA5A5};
    endfunction

    // Round-robin rule: first valid index at or after ptr, wrapping.
    function automatic int rr_pick(input logic [N_REQ-1:0] v, input int ptr);
        for (int k = 0; k < N_REQ; k++)
            if (v[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
        return -1;
    endfunction

    typedef struct {
        int          id;
        logic [15:0] op;
        int          mode;
        bit          started;
        int          st_cyc;
    } job_t;

    job_t              exp_q[$];
    int                grant_log[$];
    job_t              e;
    int                cyc, acc_cyc, ptr_m, g_m, n_rsp;
    logic              st_prev, rr_prev, rv_prev, b1, b2;
    logic [N_REQ-1:0]  acc_s;
    logic [31:0]       exp_data;
    logic              exp_err;

    int                core_mode;
    int                run_left;
    logic              st_c;
    logic [15:0]       in_c, op_c;

    // Behavioural compute core.
    initial begin
        core_busy = 1'b0; core_out = '0; run_left = 0; st_c = 1'b0; in_c = '0; op_c = '0;
        forever begin
            @(negedge clk);
            st_c = core_st;
            in_c = core_in;
            @(posedge clk); #1;
            if (!rst_n) begin
                core_busy = 1'b0;
                run_left  = 0;
            end else if (run_left > 0) begin
                run_left--;
                if (run_left == 0) begin
                    core_busy = 1'b0;
                    core_out  = core_fn(op_c);
                end else begin
                    core_out = $urandom;
                end
            end else if (st_c) begin
                op_c = in_c;
                case (core_mode)
                    0: begin core_busy = 1'b1; run_left = $urandom_range(1, 8); core_out = $urandom; end
                    1: core_out = 32'd45;
                    default: begin core_busy = 1'b1; run_left = RUN_TO + 100; core_out = $urandom; end
                endcase
            end
        end
    end

    // Scoreboard: grant order, launch timing, operand hold, response contents.
    initial begin
        cyc = 0; acc_cyc = 0; ptr_m = 0; n_rsp = 0; g_m = 0;
        st_prev = 1'b0; rr_prev = 1'b0; rv_prev = 1'b0; b1 = 1'b0; b2 = 1'b0; acc_s = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n !== 1'b1) begin
                ptr_m = 0; exp_q.delete(); acc_s = '0;
                st_prev = 1'b0; rr_prev = 1'b0; rv_prev = 1'b0;
            end else begin
                acc_s = req_valid & req_ready;
                if (req_ready != '0) begin
                    g_m = rr_pick(req_valid, ptr_m);
                    check_value("grant_onehot", req_ready, (g_m < 0) ? 64'd0 : (64'd1 << g_m));
                    check_value("ready_pulse", rr_prev, 0);
                    if (g_m >= 0 && req_ready[g_m]) begin
                        exp_q.push_back('{id: g_m, op: req_data[16*g_m +: 16], mode: -1, started: 1'b0, st_cyc: 0});
                        grant_log.push_back(g_m);
                        ptr_m   = (g_m + 1) % N_REQ;
                        acc_cyc = cyc;
                    end
                end
                if (core_st) begin
                    check_value("st_pulse", st_prev, 0);
                    check_value("st_latency", cyc - acc_cyc, 1);
                    if (exp_q.size() == 0) check_value("st_has_job", exp_q.size(), 1);
                    else begin
                        check_value("core_in", core_in, exp_q[0].op);
                        exp_q[0].mode    = core_mode;
                        exp_q[0].started = 1'b1;
                        exp_q[0].st_cyc  = cyc;
                    end
                end
                if (active && core_busy && !rsp_valid && exp_q.size() > 0 && exp_q[0].started)
                    check_value("core_in_hold", core_in, exp_q[0].op);
                if (rsp_valid && !rv_prev && exp_q.size() > 0) begin
                    if (exp_q[0].mode == 0)
                        check_value("rsp_latency", {b2, b1}, 2'b10);
                    else if (exp_q[0].mode == 1)
                        check_value("instant_latency",
                            (cyc - exp_q[0].st_cyc >= START_WAIT + 1) && (cyc - exp_q[0].st_cyc <= START_WAIT + 2), 1);
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) check_value("rsp_has_job", exp_q.size(), 1);
                    else begin
                        e = exp_q.pop_front();
                        case (e.mode)
                            0:       begin exp_data = core_fn(e.op); exp_err = 1'b0; end
                            1:       begin exp_data = 32'd45;        exp_err = 1'b0; end
                            default: begin exp_data = 32'd0;         exp_err = 1'b1; end
                        endcase
                        check_value("rsp_id", rsp_id, e.id);
                        check_value("rsp_data", rsp_data, exp_data);
                        check_value("rsp_err", rsp_err, exp_err);
                        n_rsp++;
                    end
                end
                st_prev = core_st;
                rr_prev = (req_ready != '0);
                rv_prev = rsp_valid;
            end
            b2 = b1;
            b1 = core_busy;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic issue_job(input int id, input logic [15:0] data);
        bit ok;
        ok = 1'b0;
        req_data[16*id +: 16] = data;
        req_valid[id] = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            if (acc_s[id]) ok = 1'b1;
        end
        req_valid[id] = 1'b0;
        check_value("accepted", ok, 1);
    endtask

    task automatic wait_idle(input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            tick();
            if (!active && exp_q.size() == 0 && !core_busy) ok = 1'b1;
        end
        check_value("idle_reached", ok, 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [IDW+32:0] snap;

    initial begin
        rst_n = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1; core_mode = 0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("rst_active", active, 0);
        check_value("rst_core_st", core_st, 0);
        check_value("rst_rsp_valid", rsp_valid, 0);
        check_value("rst_rsp_id", rsp_id, 0);
        check_value("rst_rsp_data", rsp_data, 0);
        check_value("rst_rsp_err", rsp_err, 0);
        check_value("rst_core_in", core_in, 0);
        check_value("rst_req_ready", req_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single job from requester 0.
        issue_job(0, 16'd2);
        wait_idle(200);

        // Contention: both requesters valid continuously from a fresh pointer.
        pulse_reset();
        grant_log.delete();
        n_rsp = 0;
        req_data  = {16'd20, 16'd10};
        req_valid = 2'b11;
        for (int i = 0; i < 400 && n_rsp < 4; i++) tick();
        req_valid = '0;
        wait_idle(200);
        check_value("contention_jobs", grant_log.size() >= 4, 1);
        if (grant_log.size() >= 4) begin
            check_value("grant_seq0", grant_log[0], 0);
            check_value("grant_seq1", grant_log[1], 1);
            check_value("grant_seq2", grant_log[2], 0);
            check_value("grant_seq3", grant_log[3], 1);
        end

        // Back-pressure: response held, no new grant while another requester waits.
        rsp_ready = 1'b0;
        issue_job(0, 16'd7);
        req_data[31:16] = 16'd99;
        req_valid[1] = 1'b1;
        for (int i = 0; i < 50 && !rsp_valid; i++) tick();
        check_value("bp_rsp_seen", rsp_valid, 1);
        snap = {rsp_id, rsp_err, rsp_data};
        repeat (20) begin
            tick();
            check_value("bp_hold", {rsp_valid, rsp_id, rsp_err, rsp_data}, {1'b1, snap});
            check_value("bp_no_st", core_st, 0);
            check_value("bp_no_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        begin : bp_release
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 50 && !ok; i++) begin
                tick();
                if (acc_s[1]) ok = 1'b1;
            end
            req_valid[1] = 1'b0;
            check_value("bp_next_accept", ok, 1);
        end
        wait_idle(200);

        // Zero-latency core.
        core_mode = 1;
        issue_job(1, 16'h0033);
        wait_idle(200);

        // Core hangs: busy outlasts the run timeout.
        core_mode = 2;
        issue_job(0, 16'h1234);
        wait_idle(6000);

        // Reset in the middle of a run.
        issue_job(1, 16'h0055);
        repeat (20) tick();
        check_value("pre_reset_active", active, 1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_value("midrst_active", active, 0);
        check_value("midrst_core_st", core_st, 0);
        check_value("midrst_rsp_valid", rsp_valid, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        core_mode = 0;
        wait_idle(200);

        // Randomized traffic with random response back-pressure.
        for (int c = 0; c < 800; c++) begin
            tick();
            rsp_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N_REQ; i++) begin
                if (acc_s[i]) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    req_data[16*i +: 16] = 16'($urandom);
                end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[16*i +: 16] = 16'($urandom);
                end
            end
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
